// File: rtl/wshb_arbiter2.sv
// Two-master / one-slave Wishbone arbiter with round-robin tie break,
// grant changes only on cycle boundaries, and a stall watchdog that
// terminates a hung slave access with err.
module wshb_arbiter2 #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // master 0 (framebuffer reader)
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_adr,
  input  logic [DATA_W-1:0]     m0_dat_ms,
  input  logic [DATA_W/8-1:0]   m0_sel,
  input  logic [2:0]            m0_cti,
  input  logic [1:0]            m0_bte,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic                  m0_rty,
  output logic [DATA_W-1:0]     m0_dat_sm,
  // master 1 (pattern writer)
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_adr,
  input  logic [DATA_W-1:0]     m1_dat_ms,
  input  logic [DATA_W/8-1:0]   m1_sel,
  input  logic [2:0]            m1_cti,
  input  logic [1:0]            m1_bte,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  m1_rty,
  output logic [DATA_W-1:0]     m1_dat_sm,
  // shared slave
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [ADDR_W-1:0]     s_adr,
  output logic [DATA_W-1:0]     s_dat_ms,
  output logic [DATA_W/8-1:0]   s_sel,
  output logic [2:0]            s_cti,
  output logic [1:0]            s_bte,
  input  logic                  s_ack,
  input  logic                  s_err,
  input  logic                  s_rty,
  input  logic [DATA_W-1:0]     s_dat_sm,
  // current owner, one-hot
  output logic [1:0]            grant
);

  localparam int SEL_W = DATA_W / 8;
  // Keep at least one bit so the disabled-watchdog build stays legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  state_e             state_q;
  logic               last_q;     // index of the master that owned the bus most recently
  logic [CNT_W-1:0]   wd_cnt_q;
  logic [CNT_W-1:0]   wd_cnt_d;

  logic               own_cyc;
  logic               own_stb;
  logic               own_we;
  logic [ADDR_W-1:0]  own_adr;
  logic [DATA_W-1:0]  own_dat;
  logic [SEL_W-1:0]   own_sel;
  logic [2:0]         own_cti;
  logic [1:0]         own_bte;

  logic               s_term;
  logic               wd_hit;
  logic               wd_fire;

  // Select the granted master's request signals; everything is zero when idle.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_cti = '0;
    own_bte = '0;
    case (state_q)
      GNT0: begin
        own_cyc = m0_cyc;
        own_stb = m0_stb;
        own_we  = m0_we;
        own_adr = m0_adr;
        own_dat = m0_dat_ms;
        own_sel = m0_sel;
        own_cti = m0_cti;
        own_bte = m0_bte;
      end
      GNT1: begin
        own_cyc = m1_cyc;
        own_stb = m1_stb;
        own_we  = m1_we;
        own_adr = m1_adr;
        own_dat = m1_dat_ms;
        own_sel = m1_sel;
        own_cti = m1_cti;
        own_bte = m1_bte;
      end
      default: ;
    endcase
  end

  assign s_term  = s_ack | s_err | s_rty;
  // A real slave termination in the final watchdog cycle wins over the abort.
  assign wd_hit  = (TIMEOUT != 0) && (wd_cnt_q == CNT_W'(TIMEOUT - 1));
  assign wd_fire = own_cyc & own_stb & ~s_term & wd_hit;

  // Watchdog next count: clears on termination, abort, idle strobe or owner release.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (!own_cyc || !own_stb || s_term || wd_fire) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != {CNT_W{1'b1}}) begin
      wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end
  end

  // Watchdog stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Grant FSM: hand over only when the owner drops cyc; ties go to the master that did not own last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_cyc && m1_cyc) begin
            state_q <= last_q ? GNT0 : GNT1;
          end else if (m0_cyc) begin
            state_q <= GNT0;
          end else if (m1_cyc) begin
            state_q <= GNT1;
          end
        end
        GNT0: begin
          if (!m0_cyc) begin
            last_q  <= 1'b0;
            state_q <= m1_cyc ? GNT1 : IDLE;
          end
        end
        GNT1: begin
          if (!m1_cyc) begin
            last_q  <= 1'b1;
            state_q <= m0_cyc ? GNT0 : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant    = state_q;

  assign s_cyc    = own_cyc;
  assign s_stb    = own_stb & ~wd_fire;
  assign s_we     = own_we;
  assign s_adr    = own_adr;
  assign s_dat_ms = own_dat;
  assign s_sel    = own_sel;
  assign s_cti    = own_cti;
  assign s_bte    = own_bte;

  assign m0_ack    = grant[0] & s_ack;
  assign m0_err    = grant[0] & (s_err | wd_fire);
  assign m0_rty    = grant[0] & s_rty;
  assign m0_dat_sm = grant[0] ? s_dat_sm : '0;

  assign m1_ack    = grant[1] & s_ack;
  assign m1_err    = grant[1] & (s_err | wd_fire);
  assign m1_rty    = grant[1] & s_rty;
  assign m1_dat_sm = grant[1] ? s_dat_sm : '0;

endmodule

// File: tb/tb_wshb_arbiter2.sv
// Randomized bench for wshb_arbiter2: three instances (TIMEOUT 256, 0, 5)
// share one stimulus and are compared every cycle against a behavioural
// model of ownership, round-robin and the stall watchdog.
module tb_wshb_arbiter2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [SW-1:0] m_sel [2];
  logic [2:0]    m_cti [2];
  logic [1:0]    m_bte [2];
  logic          s_ack, s_err, s_rty;
  logic [DW-1:0] s_dat_sm;

  logic          o_mack [ND][2];
  logic          o_merr [ND][2];
  logic          o_mrty [ND][2];
  logic [DW-1:0] o_mdat [ND][2];
  logic          o_scyc [ND];
  logic          o_sstb [ND];
  logic          o_swe  [ND];
  logic [AW-1:0] o_sadr [ND];
  logic [DW-1:0] o_sdat [ND];
  logic [SW-1:0] o_ssel [ND];
  logic [2:0]    o_scti [ND];
  logic [1:0]    o_sbte [ND];
  logic [1:0]    o_gnt  [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int TO = (g == 0) ? 256 : ((g == 1) ? 0 : 5);
    wshb_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
      .m0_dat_ms(m_dat[0]), .m0_sel(m_sel[0]), .m0_cti(m_cti[0]), .m0_bte(m_bte[0]),
      .m0_ack(o_mack[g][0]), .m0_err(o_merr[g][0]), .m0_rty(o_mrty[g][0]), .m0_dat_sm(o_mdat[g][0]),
      .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
      .m1_dat_ms(m_dat[1]), .m1_sel(m_sel[1]), .m1_cti(m_cti[1]), .m1_bte(m_bte[1]),
      .m1_ack(o_mack[g][1]), .m1_err(o_merr[g][1]), .m1_rty(o_mrty[g][1]), .m1_dat_sm(o_mdat[g][1]),
      .s_cyc(o_scyc[g]), .s_stb(o_sstb[g]), .s_we(o_swe[g]), .s_adr(o_sadr[g]),
      .s_dat_ms(o_sdat[g]), .s_sel(o_ssel[g]), .s_cti(o_scti[g]), .s_bte(o_sbte[g]),
      .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
      .grant(o_gnt[g])
    );
  end

  int n_checks = 0;
  int n_err    = 0;

  // reference model state per instance
  int own   [ND];   // -1 idle, else owning master
  int last  [ND];
  int stall [ND];   // consecutive unterminated strobe cycles seen so far

  // values observed at the most recent negedge
  logic       sn_mack [ND][2];
  logic       sn_merr [ND][2];
  logic       sn_sstb [ND];

  function automatic int to_of(int g);
    return (g == 0) ? 256 : ((g == 1) ? 0 : 5);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_models();
    for (int g = 0; g < ND; g++) begin
      own[g]   = -1;
      last[g]  = 1;
      stall[g] = 0;
    end
  endtask

  task automatic update_models();
    for (int g = 0; g < ND; g++) begin
      int   o;
      int   t;
      logic term;
      logic wd;
      o    = own[g];
      t    = to_of(g);
      term = s_ack | s_err | s_rty;
      if (o >= 0) begin
        wd = (t != 0) && m_cyc[o] && m_stb[o] && !term && (stall[g] == t - 1);
        stall[g] = (m_cyc[o] && m_stb[o] && !term && !wd) ? stall[g] + 1 : 0;
        if (!m_cyc[o]) begin
          last[g] = o;
          own[g]  = m_cyc[1-o] ? 1 - o : -1;
        end
      end else begin
        stall[g] = 0;
        if (m_cyc[0] && m_cyc[1]) own[g] = 1 - last[g];
        else if (m_cyc[0])        own[g] = 0;
        else if (m_cyc[1])        own[g] = 1;
      end
    end
  endtask

  task automatic check_outputs();
    for (int g = 0; g < ND; g++) begin
      int          o;
      int          t;
      logic        wd;
      logic [1:0]  eg;
      logic [11:0] ectl;
      logic [AW-1:0] eadr;
      logic [DW-1:0] edat;
      logic [5:0]  eterm;
      logic [63:0] emdat;
      o = own[g]; t = to_of(g);
      wd = 1'b0; eg = '0; ectl = '0; eadr = '0; edat = '0; eterm = '0; emdat = '0;
      if (o >= 0) begin
        wd   = (t != 0) && m_cyc[o] && m_stb[o] && !s_ack && !s_err && !s_rty && (stall[g] == t - 1);
        eg   = (o == 0) ? 2'b01 : 2'b10;
        ectl = {m_cyc[o], m_stb[o] & !wd, m_we[o], m_sel[o], m_cti[o], m_bte[o]};
        eadr = m_adr[o];
        edat = m_dat[o];
        if (o == 0) begin
          eterm = {s_ack, s_err | wd, s_rty, 3'b000};
          emdat = {s_dat_sm, {DW{1'b0}}};
        end else begin
          eterm = {3'b000, s_ack, s_err | wd, s_rty};
          emdat = {{DW{1'b0}}, s_dat_sm};
        end
      end
      check($sformatf("i%0d grant", g), 64'(o_gnt[g]), 64'(eg));
      check($sformatf("i%0d s_ctl", g),
            64'({o_scyc[g], o_sstb[g], o_swe[g], o_ssel[g], o_scti[g], o_sbte[g]}), 64'(ectl));
      check($sformatf("i%0d s_adr", g), 64'(o_sadr[g]), 64'(eadr));
      check($sformatf("i%0d s_dat_ms", g), 64'(o_sdat[g]), 64'(edat));
      check($sformatf("i%0d m_term", g),
            64'({o_mack[g][0], o_merr[g][0], o_mrty[g][0], o_mack[g][1], o_merr[g][1], o_mrty[g][1]}),
            64'(eterm));
      check($sformatf("i%0d m_dat_sm", g), {o_mdat[g][0], o_mdat[g][1]}, emdat);
      sn_mack[g][0] = o_mack[g][0];
      sn_mack[g][1] = o_mack[g][1];
      sn_merr[g][0] = o_merr[g][0];
      sn_merr[g][1] = o_merr[g][1];
      sn_sstb[g]    = o_sstb[g];
    end
  endtask

  // one clock: compare at negedge, advance model at posedge, return just after it
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (rst_n) update_models();
    else       reset_models();
    #1;
  endtask

  task automatic rand_data();
    for (int n = 0; n < 2; n++) begin
      m_we[n]  = 1'($urandom_range(0, 1));
      m_adr[n] = $urandom;
      m_dat[n] = $urandom;
      m_sel[n] = 4'($urandom_range(0, 15));
      m_cti[n] = 3'($urandom_range(0, 7));
      m_bte[n] = 2'($urandom_range(0, 3));
    end
    s_dat_sm = $urandom;
  endtask

  task automatic rand_inputs(input int ack_pct);
    rand_data();
    for (int n = 0; n < 2; n++) begin
      if (m_cyc[n]) begin
        if ($urandom_range(0, 7) == 0) m_cyc[n] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        m_cyc[n] = 1'b1;
      end
      m_stb[n] = m_cyc[n] & ($urandom_range(0, 3) != 0);
    end
    s_ack = ($urandom_range(0, 99) < ack_pct);
    s_err = ($urandom_range(0, 15) == 0);
    s_rty = ($urandom_range(0, 15) == 0);
  endtask

  task automatic idle_masters();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  initial begin
    int         a0, a1, e0, e1, e2, first, changes, burst, reraise;
    logic       stb_at;
    logic [1:0] prevg, expg;

    rst_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      m_we[n] = 1'b0; m_adr[n] = '0; m_dat[n] = '0;
      m_sel[n] = '0; m_cti[n] = '0; m_bte[n] = '0;
    end
    s_dat_sm = '0;
    idle_masters();
    reset_models();
    repeat (3) step();
    check("reset grant", 64'(o_gnt[0]), 64'd0);
    check("reset outs", 64'({o_scyc[0], o_sstb[0], o_mack[0][0], o_mack[0][1]}), 64'd0);
    rst_n = 1'b1;
    step();

    // simultaneous request: m0 wins the first tie, then direct handover to m1
    rand_data();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    check("tie first grant", 64'(o_gnt[0]), 64'd1);
    repeat (8) begin
      rand_data();
      s_ack = 1'($urandom_range(0, 1));
      step();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();
    check("handover grant", 64'(o_gnt[0]), 64'd2);
    check("handover s_adr", 64'(o_sadr[0]), 64'(m_adr[1]));
    idle_masters();
    repeat (2) step();

    // m1 writes 64 words alone
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    step();
    a0 = 0; a1 = 0;
    for (int i = 0; i < 64; i++) begin
      rand_data();
      m_we[1] = 1'b1;
      s_ack = 1'b1;
      step();
      a1 += int'(sn_mack[0][1]);
      a0 += int'(sn_mack[0][0]);
    end
    check("m1 ack count", 64'(a1), 64'd64);
    check("m0 ack count", 64'(a0), 64'd0);
    idle_masters();
    repeat (2) step();

    // alternating contention with immediate re-request
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    prevg = 2'b00; changes = 0; burst = $urandom_range(1, 4); reraise = -1;
    for (int c = 0; c < 400 && changes < 17; c++) begin
      rand_data();
      s_ack = 1'($urandom_range(0, 1));
      if (reraise >= 0) begin
        m_cyc[reraise] = 1'b1; m_stb[reraise] = 1'b1; reraise = -1;
      end
      if (own[0] >= 0) begin
        if (burst == 0) begin
          m_cyc[own[0]] = 1'b0; m_stb[own[0]] = 1'b0;
          reraise = own[0];
          burst = $urandom_range(1, 4);
        end else begin
          burst--;
        end
      end
      step();
      if (o_gnt[0] != prevg) begin
        if (prevg != 2'b00) begin
          expg = ~prevg;
          check("alternate grant", 64'(o_gnt[0]), 64'(expg));
        end
        prevg = o_gnt[0];
        changes++;
      end
    end
    check("alternate rounds", 64'(changes >= 17), 64'd1);
    idle_masters();
    repeat (2) step();

    // hung slave: watchdog aborts on the TIMEOUT-th strobe cycle
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    first = -1; stb_at = 1'b1; e1 = 0; e2 = 0;
    for (int k = 1; k <= 300; k++) begin
      rand_data();
      step();
      if (sn_merr[0][0] && first < 0) begin
        first  = k;
        stb_at = sn_sstb[0];
      end
      e1 += int'(sn_merr[1][0]);
      e2 += int'(sn_merr[2][0]);
    end
    check("wd err cycle", 64'(first), 64'd256);
    check("wd s_stb low", 64'(stb_at), 64'd0);
    check("wd disabled errs", 64'(e1), 64'd0);
    check("wd t5 errs", 64'(e2), 64'd60);
    idle_masters();
    repeat (2) step();

    // ack on stall cycle 255 beats the watchdog and restarts its count
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    e0 = 0;
    for (int k = 1; k <= 255; k++) begin
      s_ack = (k == 255);
      step();
      if (k < 255) e0 += int'(sn_merr[0][0]);
    end
    check("late ack delivered", 64'(sn_mack[0][0]), 64'd1);
    check("late ack no err", 64'(sn_merr[0][0]), 64'd0);
    check("no early err", 64'(e0), 64'd0);
    s_ack = 1'b0;
    first = -1;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (sn_merr[0][0] && first < 0) first = k;
    end
    check("wd restart cycle", 64'(first), 64'd256);
    idle_masters();
    repeat (2) step();

    // random traffic, frequent and sparse acks
    for (int i = 0; i < 2000; i++) begin rand_inputs(50); step(); end
    for (int i = 0; i < 2000; i++) begin rand_inputs(10); step(); end
    idle_masters();
    repeat (2) step();

    // reset asserted mid-burst under m1
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    s_ack = 1'b1;
    repeat (2) step();
    check("pre-reset burst", 64'({o_scyc[0], o_sstb[0], o_gnt[0], o_mack[0][1]}), 64'b11101);
    #2;
    rst_n = 1'b0;
    reset_models();
    #1;
    check("async reset outs", 64'({o_scyc[0], o_sstb[0], o_gnt[0], o_mack[0][1]}), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    idle_masters();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    for (int g = 0; g < ND; g++) check($sformatf("i%0d post-reset tie", g), 64'(o_gnt[g]), 64'd1);
    repeat (3) begin rand_data(); step(); end
    idle_masters();
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
